// File: rtl/wb_arbiter_rr_b3_if.sv
// Wishbone B3 classic bus bundle shared by the round-robin arbiter, its masters and the downstream slave.
interface wb_arbiter_rr_b3_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_m2s;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_s2m;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (output cyc, stb, we, adr, dat_m2s, sel, cti, bte,
                    input  dat_s2m, ack, err, rty);
    modport slave  (input  cyc, stb, we, adr, dat_m2s, sel, cti, bte,
                    output dat_s2m, ack, err, rty);
endinterface

// File: rtl/wb_arbiter_rr_b3.sv
// N-master Wishbone B3 arbiter: registered round-robin grant held for the whole CYC,
// with a per-transfer watchdog that terminates a hung transfer with a one-cycle ERR.
module wb_arbiter_rr_b3 #(
    parameter int MASTERS = 3,
    parameter int TIMEOUT = 255,
    parameter int TO_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_arbiter_rr_b3_if.slave  master [0:MASTERS-1],
    wb_arbiter_rr_b3_if.master slave,
    output logic [MASTERS-1:0] grant,
    output logic               timeout
);
    localparam int                 IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam bit                 WD_ON     = (TIMEOUT > 0);
    localparam logic [TO_BITS-1:0] WD_LAST   = TO_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0]   PTR_RESET = IDX_W'(MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t             state_r;
    logic [MASTERS-1:0] grant_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [TO_BITS-1:0] wd_cnt_r;
    logic               timeout_r;

    logic [MASTERS-1:0] m_cyc_s;
    logic [MASTERS-1:0] m_stb_s;
    logic [MASTERS-1:0] m_we_s;
    logic [31:0]        m_adr_s [MASTERS];
    logic [31:0]        m_dat_s [MASTERS];
    logic [3:0]         m_sel_s [MASTERS];
    logic [2:0]         m_cti_s [MASTERS];
    logic [1:0]         m_bte_s [MASTERS];

    logic               own_s;
    logic               abort_s;
    logic               owner_cyc_s;
    logic               owner_stb_s;
    logic               resp_s;
    logic               waiting_s;
    logic               any_req_s;
    logic [IDX_W-1:0]   next_idx_s;

    logic               bus_cyc_s;
    logic               bus_stb_s;
    logic               bus_we_s;
    logic [31:0]        bus_adr_s;
    logic [31:0]        bus_dat_s;
    logic [3:0]         bus_sel_s;
    logic [2:0]         bus_cti_s;
    logic [1:0]         bus_bte_s;

    function automatic logic [MASTERS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [MASTERS-1:0] v;
        for (int i = 0; i < MASTERS; i++) begin
            v[i] = (IDX_W'(i) == idx);
        end
        return v;
    endfunction

    // First requester after 'last' in circular order; descending scan lets the nearest one win.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = last;
        for (int k = MASTERS; k >= 1; k--) begin
            idx = (int'(last) + k) % MASTERS;
            if (|(req & to_onehot(IDX_W'(idx)))) begin
                pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    for (genvar g = 0; g < MASTERS; g++) begin : g_port
        assign m_cyc_s[g] = master[g].cyc;
        assign m_stb_s[g] = master[g].stb;
        assign m_we_s[g]  = master[g].we;
        assign m_adr_s[g] = master[g].adr;
        assign m_dat_s[g] = master[g].dat_m2s;
        assign m_sel_s[g] = master[g].sel;
        assign m_cti_s[g] = master[g].cti;
        assign m_bte_s[g] = master[g].bte;

        // Non-owners never see a response, so no master can mistake another's ack for its own.
        assign master[g].ack     = own_s & grant_r[g] & slave.ack;
        assign master[g].err     = (own_s & grant_r[g] & slave.err) | (abort_s & grant_r[g]);
        assign master[g].rty     = own_s & grant_r[g] & slave.rty;
        assign master[g].dat_s2m = (own_s & grant_r[g]) ? slave.dat_s2m : 32'h0000_0000;
    end

    // Reset gates the bus immediately rather than waiting for the state to clear.
    assign own_s       = (state_r == OWN) && !rst;
    assign abort_s     = (state_r == ABORT) && !rst;
    assign owner_cyc_s = |(m_cyc_s & grant_r);
    assign owner_stb_s = |(m_stb_s & grant_r);
    assign resp_s      = slave.ack | slave.err | slave.rty;
    assign waiting_s   = owner_stb_s & ~resp_s;
    assign any_req_s   = |m_cyc_s;
    assign next_idx_s  = rr_pick(m_cyc_s, ptr_r);

    // AND-OR mux of the owner's request onto the shared bus; zero when not owning.
    always_comb begin
        bus_cyc_s = 1'b0;
        bus_stb_s = 1'b0;
        bus_we_s  = 1'b0;
        bus_adr_s = 32'h0000_0000;
        bus_dat_s = 32'h0000_0000;
        bus_sel_s = 4'h0;
        bus_cti_s = 3'h0;
        bus_bte_s = 2'h0;
        for (int i = 0; i < MASTERS; i++) begin
            bus_cyc_s = bus_cyc_s | (m_cyc_s[i] & own_s & grant_r[i]);
            bus_stb_s = bus_stb_s | (m_stb_s[i] & own_s & grant_r[i]);
            bus_we_s  = bus_we_s  | (m_we_s[i]  & own_s & grant_r[i]);
            bus_adr_s = bus_adr_s | (m_adr_s[i] & {32{own_s & grant_r[i]}});
            bus_dat_s = bus_dat_s | (m_dat_s[i] & {32{own_s & grant_r[i]}});
            bus_sel_s = bus_sel_s | (m_sel_s[i] & {4{own_s & grant_r[i]}});
            bus_cti_s = bus_cti_s | (m_cti_s[i] & {3{own_s & grant_r[i]}});
            bus_bte_s = bus_bte_s | (m_bte_s[i] & {2{own_s & grant_r[i]}});
        end
    end

    assign slave.cyc     = bus_cyc_s;
    assign slave.stb     = bus_stb_s;
    assign slave.we      = bus_we_s;
    assign slave.adr     = bus_adr_s;
    assign slave.dat_m2s = bus_dat_s;
    assign slave.sel     = bus_sel_s;
    assign slave.cti     = bus_cti_s;
    assign slave.bte     = bus_bte_s;

    assign grant   = grant_r;
    assign timeout = timeout_r;

    // Arbitration, ownership and watchdog state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            ptr_r     <= PTR_RESET;
            wd_cnt_r  <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    wd_cnt_r <= '0;
                    if (any_req_s) begin
                        state_r <= OWN;
                        grant_r <= to_onehot(next_idx_s);
                        ptr_r   <= next_idx_s;
                    end else begin
                        grant_r <= '0;
                    end
                end
                OWN: begin
                    // Abort takes priority so a CYC drop on the abort edge still gets its ERR.
                    if (WD_ON && waiting_s && (wd_cnt_r == WD_LAST)) begin
                        state_r   <= ABORT;
                        timeout_r <= 1'b1;
                        wd_cnt_r  <= '0;
                    end else if (!owner_cyc_s) begin
                        wd_cnt_r <= '0;
                        if (any_req_s) begin
                            grant_r <= to_onehot(next_idx_s);
                            ptr_r   <= next_idx_s;
                        end else begin
                            state_r <= IDLE;
                            grant_r <= '0;
                        end
                    end else if (WD_ON && waiting_s) begin
                        wd_cnt_r <= wd_cnt_r + TO_BITS'(1);
                    end else begin
                        wd_cnt_r <= '0;
                    end
                end
                ABORT: begin
                    wd_cnt_r <= '0;
                    if (owner_cyc_s) begin
                        state_r <= OWN;
                    end else if (any_req_s) begin
                        state_r <= OWN;
                        grant_r <= to_onehot(next_idx_s);
                        ptr_r   <= next_idx_s;
                    end else begin
                        state_r <= IDLE;
                        grant_r <= '0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    grant_r  <= '0;
                    wd_cnt_r <= '0;
                end
            endcase
        end
    end
endmodule
